usr_serial_rx: RTL and testbench

//  Serial-to-parallel frame receiver: the far end of the universal shift register's serial output.

---
 rtl/usr_serial_rx.sv | 157 +++++++++++++++
 tb/tb_usr_serial_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/usr_serial_rx.sv
// -----------------------------------------------------------------------------
// usr_serial_rx
// Serial-to-parallel frame receiver for the universal shift register link.
// A frame on serialin is: start bit (0), WIDTH data bits, stop bit (1).
// serialin is sampled only on clock edges where bit_en=1. A good frame is
// presented on a valid/ready output. Framing errors and overruns are reported
// as one-cycle pulses.
//
// Parameters
//   WIDTH      data bits per frame (>=2)
//   MSB_FIRST  1: first received data bit lands in data_out[WIDTH-1]
//              0: first received data bit lands in data_out[0]
//
// Ports
//   clk        clock; all state changes on posedge
//   reset      synchronous active-high reset
//   serialin   serial line (idles high)
//   bit_en     sample strobe
//   out_ready  consumer accepts data_out this cycle
//   data_out   received word; stable while out_valid=1
//   out_valid  data_out holds an unconsumed word
//   busy       receiver is inside a frame
//   frame_err  one-cycle pulse: stop bit sampled as 0
//   overrun    one-cycle pulse: good frame dropped, holding register full
// -----------------------------------------------------------------------------
module usr_serial_rx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serialin,
    input  logic             bit_en,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_STOP = 2'b10
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]   sr_r, sr_nxt_s;
    logic [WIDTH-1:0]   data_r, data_nxt_s;
    logic               valid_r, valid_nxt_s;
    logic               busy_r;
    logic               ferr_r, ferr_nxt_s;
    logic               ovr_r, ovr_nxt_s;
    logic               xfer_s;

    assign xfer_s = valid_r & out_ready;

    // Next-state, shift-register and output-handshake logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        sr_nxt_s    = sr_r;
        data_nxt_s  = data_r;
        valid_nxt_s = valid_r;
        ferr_nxt_s  = 1'b0;
        ovr_nxt_s   = 1'b0;

        // A transfer empties the holding register unless a load below refills it.
        if (xfer_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end

        if (bit_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (!serialin) begin
                        state_nxt_s = ST_DATA;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (MSB_FIRST != 0) begin
                        sr_nxt_s = {sr_r[WIDTH-2:0], serialin};
                    end else begin
                        sr_nxt_s = {serialin, sr_r[WIDTH-1:1]};
                    end
                    // Leave the counter at zero on exit so it never wraps.
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_STOP;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_STOP: begin
                    // A 0 stop bit is an error, never a new start bit.
                    state_nxt_s = ST_IDLE;
                    if (serialin) begin
                        if (!valid_r || xfer_s) begin
                            data_nxt_s  = sr_r;
                            valid_nxt_s = 1'b1;
                        end else begin
                            ovr_nxt_s   = 1'b1;
                        end
                    end else begin
                        ferr_nxt_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            sr_r    <= {WIDTH{1'b0}};
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sr_r    <= sr_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            ferr_r  <= ferr_nxt_s;
            ovr_r   <= ovr_nxt_s;
        end
    end

    assign data_out  = data_r;
    assign out_valid = valid_r;
    assign busy      = busy_r;
    assign frame_err = ferr_r;
    assign overrun   = ovr_r;

endmodule

// File: tb/tb_usr_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_usr_serial_rx
// Drives two receivers (MSB-first and LSB-first) from one serial line with
// randomized frames, sample strobes, back-pressure and resets, and compares
// every output each cycle against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_usr_serial_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         serialin = 1'b1;
    logic         bit_en = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] data_hi, data_lo;
    logic         valid_hi, valid_lo, busy_hi, busy_lo;
    logic         ferr_hi, ferr_lo, ovr_hi, ovr_lo;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    usr_serial_rx #(.WIDTH(W), .MSB_FIRST(1)) u_dut_hi (
        .clk(clk), .reset(reset), .serialin(serialin), .bit_en(bit_en),
        .out_ready(out_ready), .data_out(data_hi), .out_valid(valid_hi),
        .busy(busy_hi), .frame_err(ferr_hi), .overrun(ovr_hi)
    );

    usr_serial_rx #(.WIDTH(W), .MSB_FIRST(0)) u_dut_lo (
        .clk(clk), .reset(reset), .serialin(serialin), .bit_en(bit_en),
        .out_ready(out_ready), .data_out(data_lo), .out_valid(valid_lo),
        .busy(busy_lo), .frame_err(ferr_lo), .overrun(ovr_lo)
    );

    // Reference model: position in frame (-1 idle, 0..W-1 data bits taken,
    // W awaiting stop) and the data bits in line order.
    int   m_pos = -1;
    logic m_bits [W];
    int   m_data_hi = 0, m_data_lo = 0;
    logic m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

    logic line_q [$];

    task automatic check_eq(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Append one frame to the line: idle gap, start, random data, mostly-good stop.
    task automatic gen_frame();
        int gap;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) line_q.push_back(1'b1);
        line_q.push_back(1'b0);
        for (int i = 0; i < W; i++) line_q.push_back(1'($urandom_range(0, 1)));
        line_q.push_back($urandom_range(0, 7) != 0);
    endtask

    task automatic model_step();
        logic xfer, load;
        if (reset) begin
            m_pos = -1; m_data_hi = 0; m_data_lo = 0;
            m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        end else begin
            m_ferr = 1'b0; m_ovr = 1'b0; load = 1'b0;
            xfer = m_valid && out_ready;
            if (bit_en) begin
                if (m_pos < 0) begin
                    if (serialin == 1'b0) m_pos = 0;
                end else if (m_pos < W) begin
                    m_bits[m_pos] = serialin;
                    m_pos++;
                end else begin
                    m_pos = -1;
                    if (serialin) begin
                        if (!m_valid || xfer) load = 1'b1;
                        else m_ovr = 1'b1;
                    end else begin
                        m_ferr = 1'b1;
                    end
                end
            end
            if (load) begin
                m_data_hi = 0; m_data_lo = 0;
                for (int i = 0; i < W; i++) begin
                    m_data_hi += int'(m_bits[i]) << (W - 1 - i);
                    m_data_lo += int'(m_bits[i]) << i;
                end
                m_valid = 1'b1;
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("data_hi",  int'(data_hi),  m_data_hi);
        check_eq("data_lo",  int'(data_lo),  m_data_lo);
        check_eq("valid_hi", int'(valid_hi), int'(m_valid));
        check_eq("valid_lo", int'(valid_lo), int'(m_valid));
        check_eq("busy_hi",  int'(busy_hi),  int'(m_pos >= 0));
        check_eq("busy_lo",  int'(busy_lo),  int'(m_pos >= 0));
        check_eq("ferr_hi",  int'(ferr_hi),  int'(m_ferr));
        check_eq("ferr_lo",  int'(ferr_lo),  int'(m_ferr));
        check_eq("ovr_hi",   int'(ovr_hi),   int'(m_ovr));
        check_eq("ovr_lo",   int'(ovr_lo),   int'(m_ovr));
        check_eq("no_ferr_ovr_same_cycle", int'(ferr_hi & ovr_hi), 0);
    endtask

    // One clock: drive inputs at negedge, advance the model, check after posedge.
    task automatic cycle(input logic rst, input logic en, input logic rdy);
        @(negedge clk);
        reset = rst; bit_en = en; out_ready = rdy;
        if (en) begin
            if (line_q.size() == 0) gen_frame();
            serialin = line_q.pop_front();
        end else begin
            serialin = 1'($urandom_range(0, 1));
        end
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int rdy_pct, en_pct;

        // Reset state.
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("reset_data", int'(data_hi), 0);
        check_eq("reset_valid", int'(valid_hi), 0);

        // Directed frame 0,1,0,1,1,1 with no consumer.
        line_q.delete();
        line_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);
        check_eq("ex_msb_first", int'(data_hi), 4'hB);
        check_eq("ex_lsb_first", int'(data_lo), 4'hD);
        check_eq("ex_valid", int'(valid_hi), 1);

        // Second good frame while holding register is full: overrun.
        line_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);
        check_eq("ovr_pulse", int'(ovr_hi), 1);
        check_eq("ovr_keeps_data", int'(data_hi), 4'hB);
        cycle(1'b0, 1'b0, 1'b1);
        check_eq("ovr_clears", int'(ovr_hi), 0);
        check_eq("ready_clears_valid", int'(valid_hi), 0);

        // Bad stop bit.
        line_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);
        check_eq("ferr_pulse", int'(ferr_hi), 1);
        check_eq("ferr_no_valid", int'(valid_hi), 0);

        // Randomized phases of strobe density and back-pressure.
        line_q.delete();
        for (int ph = 0; ph < 16; ph++) begin
            case (ph % 4)
                0: rdy_pct = 0;
                1: rdy_pct = 25;
                2: rdy_pct = 75;
                default: rdy_pct = 100;
            endcase
            en_pct = (ph < 8) ? 100 : 60;
            for (int c = 0; c < 200; c++) begin
                cycle($urandom_range(0, 299) == 0,
                      $urandom_range(0, 99) < en_pct,
                      $urandom_range(0, 99) < rdy_pct);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
